i2s_stereo_rx: RTL and testbench
================================

Name: i2s_stereo_rx

Overview:
- I2S master receiver for the two-microphone front end.
- Generates BCLK/LRCLK for a pair of I2S MEMS mics sharing one SD line: mic A strapped to the left slot, mic B to the right slot.
- Deserialises both slots and presents a time-aligned signed 16-bit pair with a one-cycle sample_valid strobe.
- It is the producer side of the sample stream consumed by the TDOA correlator.

Parameters:
- CLK_DIV, 8: clk cycles per BCLK half-period, minimum 4. With 48 MHz clk this gives BCLK = 3 MHz and fs = 46.875 kHz.
- SAMPLE_W, 16: output sample width. The top SAMPLE_W bits of each slot are kept and the rest are discarded.
- SLOT_BITS, 32: BCLK cycles per channel slot. A frame is 2*SLOT_BITS. SAMPLE_W + 1 must not exceed SLOT_BITS.
- STARTUP_FRAMES, 4096: frames discarded after enable while the mics settle. A value of 0 means no discard.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run the interface; low stops the clocks
- i2s_bclk  out  1  bit clock to both mics
- i2s_lrclk  out  1  word select; 0 = left/mic A, 1 = right/mic B
- i2s_sd  in  1  shared serial data, asynchronous to clk
- sample_valid  out  1  one-cycle strobe; new pair is on mic_A_out/mic_B_out
- mic_A_out  out  SAMPLE_W  signed sample, mic A (left slot)
- mic_B_out  out  SAMPLE_W  signed sample, mic B (right slot)

Behaviour:
- Reset (async assert, sync release): all of the following are cleared.
  - state=IDLE; i2s_bclk=0; i2s_lrclk=0; sample_valid=0.
  - mic_A_out=0; mic_B_out=0.
  - All counters and the shift register = 0.
- i2s_sd passes through a 2-flop synchroniser before any use.
- Divider counts 0..CLK_DIV-1. At the terminal count, BCLK toggles.
  - Terminal count with bclk=0: rise event.
  - Terminal count with bclk=1: fall event.
- Slot counter slot (0..2*SLOT_BITS-1) increments on each fall event and wraps.
  - i2s_lrclk = (slot >= SLOT_BITS), registered, so it changes only on BCLK falling edges.
- Capture point is the fall event: the synchronised SD value is taken at the end of the BCLK high phase, before the mic changes data.
- I2S one-bit delay applies: the MSB sits in slot 1 of each channel.
  - Bits are captured when slot is in 1..SAMPLE_W (left) or SLOT_BITS+1..SLOT_BITS+SAMPLE_W (right).
  - Shift order is MSB first, shifting left.
- Left word completion: when the left slot's last kept bit is shifted in, the word is copied to an internal hold register. mic_A_out does not change yet.
- Right word completion: when the right word completes, it is held likewise.
- Frame completion (fall event at slot 2*SLOT_BITS-1, RUN state only):
  - On the next clk edge, mic_A_out and mic_B_out load both held words simultaneously.
  - sample_valid is high for exactly that one cycle.
- Between strobes the outputs hold their value. Steady-state strobe period is 2*CLK_DIV*2*SLOT_BITS clk cycles (1024 at defaults).
- States:
  - IDLE: bclk=0, lrclk=0, divider and slot counter held at 0.
    - enable=1 → WARMUP, or RUN directly if STARTUP_FRAMES=0.
  - WARMUP: clocks run and data is captured but not published.
    - The frame counter increments at each frame completion.
    - After STARTUP_FRAMES completions → RUN.
  - RUN: publishes every completed frame.
  - In WARMUP or RUN, enable=0 → IDLE on the next cycle.
    - The partial frame is dropped and no strobe is issued.
    - BCLK is forced low and the output registers keep their last values.
    - Re-enable restarts warm-up from 0.
- Frame completion and enable falling in the same cycle: enable wins and no strobe is issued.
- Reset mid-frame: immediate return to reset values; no strobe.
- The first RUN strobe publishes only a frame captured entirely after warm-up completed; no partial frames are published.

Decomposition:
- Shared package tdoa_pkg:
  - SAMPLE_W constant.
  - rx_state_t enum (IDLE, WARMUP, RUN).
  - Frame-geometry constants reused by the correlator for sample-rate-derived limits.
- Sub-module i2s_clkgen:
  - Contains the divider, BCLK/LRCLK generation and slot counter.
  - Outputs bclk, lrclk, slot, rise_evt, fall_evt and frame_end.
  - Takes a run input.
- Capture, warm-up and output logic stay in i2s_stereo_rx.

Test Plan:
- Reset behaviour: rst pulse mid-RUN → within the same cycle, i2s_bclk=0, i2s_lrclk=0, sample_valid=0, mic_A_out=mic_B_out=0. After release with enable=1, BCLK restarts at divider 0.
- Clock generation: CLK_DIV=8 → BCLK period 16 clk at 50% duty and LRCLK period 1024 clk. LRCLK edges coincide only with BCLK falling edges.
- Data capture: behavioural mic model drives 24-bit left 0x123456 and right 0xFEDCBA on falling edges. The model uses 1-bit delay and 3-cycle output delay, with STARTUP_FRAMES=0. Expect mic_A_out=0x1234 and mic_B_out=0xFEDC (signed -292), with a sample_valid pulse every 1024 cycles.
- Sign extremes: left 0x800000, right 0x7FFFFF → mic_A_out=-32768, mic_B_out=32767.
- Warm-up: STARTUP_FRAMES=3 → no strobe during the first 3 frames. The first strobe appears at the end of frame 4 and carries frame-4 data.
- Enable drop: enable=0 at slot 40 → no strobe, BCLK is low by the next cycle, and outputs hold their prior pair. Re-enabling repeats the full warm-up.

Source files
------------

// File: rtl/tdoa_pkg.sv
// Shared definitions for the two-microphone front end and the TDOA correlator.
package tdoa_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int CLK_DIV_DEF   = 8;
    localparam int SLOT_BITS_DEF = 32;

    // Frame geometry at the default settings, used by the correlator to derive
    // sample-rate dependent limits.
    localparam int FRAME_BITS = 2 * SLOT_BITS_DEF;
    localparam int FRAME_CLKS = 2 * CLK_DIV_DEF * FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } rx_state_t;

    // clk cycles per stereo frame for an arbitrary divider / slot length
    function automatic int frame_clks(input int clk_div, input int slot_bits);
        return 2 * clk_div * 2 * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK / LRCLK generator with slot counter. Everything is held at zero while
// run is low, so a restart always begins at divider 0, slot 0, BCLK low.
module i2s_clkgen #(
    parameter int CLK_DIV   = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    output logic                             bclk,
    output logic                             lrclk,
    output logic [$clog2(2*SLOT_BITS)-1:0]   slot,
    output logic                             rise_evt,
    output logic                             fall_evt,
    output logic                             frame_end
);
    localparam int SLOT_W = $clog2(2*SLOT_BITS);
    localparam int DIV_W  = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2*SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SLOT_BITS);

    logic [DIV_W-1:0]  div;
    logic              tc;
    logic [SLOT_W-1:0] slot_nxt;

    assign tc        = run && (div == DIV_TC);
    assign rise_evt  = tc && !bclk;
    assign fall_evt  = tc && bclk;
    assign frame_end = fall_evt && (slot == SLOT_LAST);
    assign slot_nxt  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;

    // Divider, BCLK toggle and slot/word-select tracking; LRCLK only moves on a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
            slot  <= '0;
        end else if (!run) begin
            div   <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
            slot  <= '0;
        end else begin
            div <= tc ? '0 : div + 1'b1;
            if (tc) begin
                bclk <= !bclk;
            end
            if (fall_evt) begin
                slot  <= slot_nxt;
                lrclk <= (slot_nxt >= SLOT_HALF);
            end
        end
    end

endmodule

// File: rtl/i2s_stereo_rx.sv
// I2S master receiver for two MEMS mics sharing one SD line (A = left slot,
// B = right slot). Publishes a time-aligned signed pair once per frame.
module i2s_stereo_rx #(
    parameter int CLK_DIV        = 8,
    parameter int SAMPLE_W       = tdoa_pkg::SAMPLE_W,
    parameter int SLOT_BITS      = 32,
    parameter int STARTUP_FRAMES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    input  logic                i2s_sd,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] mic_A_out,
    output logic [SAMPLE_W-1:0] mic_B_out
);
    import tdoa_pkg::*;

    localparam int SLOT_W = $clog2(2*SLOT_BITS);
    localparam int FC_W   = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;

    localparam logic [FC_W-1:0] FC_LAST =
        FC_W'((STARTUP_FRAMES > 0) ? STARTUP_FRAMES - 1 : 0);

    // One-bit I2S delay: the MSB of each channel sits in slot 1 of that channel.
    localparam logic [SLOT_W-1:0] L_FIRST = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] L_LAST  = SLOT_W'(SAMPLE_W);
    localparam logic [SLOT_W-1:0] R_FIRST = SLOT_W'(SLOT_BITS + 1);
    localparam logic [SLOT_W-1:0] R_LAST  = SLOT_W'(SLOT_BITS + SAMPLE_W);

    rx_state_t         state;
    logic [FC_W-1:0]   frame_cnt;
    logic              run;
    logic              sd_meta;
    logic              sd_sync;
    logic [SLOT_W-1:0] slot;
    logic              fall_evt;
    logic              frame_end;
    logic              unused_rise;      // capture only needs fall events
    logic              in_window;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] shreg_nxt;
    logic [SAMPLE_W-1:0] hold_a;
    logic [SAMPLE_W-1:0] hold_b;

    // Clocks run in WARMUP/RUN; dropping enable stops them on the same edge
    // that moves the FSM to IDLE, so BCLK is low one cycle after enable falls.
    assign run = enable && (state != IDLE);

    i2s_clkgen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bclk      (i2s_bclk),
        .lrclk     (i2s_lrclk),
        .slot      (slot),
        .rise_evt  (unused_rise),
        .fall_evt  (fall_evt),
        .frame_end (frame_end)
    );

    assign in_window = ((slot >= L_FIRST) && (slot <= L_LAST)) ||
                       ((slot >= R_FIRST) && (slot <= R_LAST));
    assign shreg_nxt = {shreg[SAMPLE_W-2:0], sd_sync};

    // Two-flop synchroniser for the mic data line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_meta <= 1'b0;
            sd_sync <= 1'b0;
        end else begin
            sd_meta <= i2s_sd;
            sd_sync <= sd_meta;
        end
    end

    // Shift in kept bits at the end of each BCLK high phase; park finished words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            hold_a <= '0;
            hold_b <= '0;
        end else if (run && fall_evt && in_window) begin
            shreg <= shreg_nxt;
            if (slot == L_LAST) begin
                hold_a <= shreg_nxt;
            end
            if (slot == R_LAST) begin
                hold_b <= shreg_nxt;
            end
        end
    end

    // Warm-up / run sequencing and the registered output pair with its strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            sample_valid <= 1'b0;
            mic_A_out    <= '0;
            mic_B_out    <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    frame_cnt <= '0;
                    if (enable) begin
                        state <= (STARTUP_FRAMES == 0) ? RUN : WARMUP;
                    end
                end
                WARMUP: begin
                    if (!enable) begin
                        state     <= IDLE;
                        frame_cnt <= '0;
                    end else if (frame_end) begin
                        if (frame_cnt == FC_LAST) begin
                            state     <= RUN;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (frame_end) begin
                        sample_valid <= 1'b1;
                        mic_A_out    <= hold_a;
                        mic_B_out    <= hold_b;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Bench for i2s_stereo_rx: behavioural I2S mic pair plus a scoreboard of
// expected output pairs checked at every sample_valid strobe.
module tb_i2s_stereo_rx;

    localparam int CLK_DIV    = 8;
    localparam int SLOT_BITS  = 32;
    localparam int SAMPLE_W   = 16;
    localparam int STARTUP    = 3;
    localparam int FRAME_CLKS = 2 * CLK_DIV * 2 * SLOT_BITS;
    localparam int FIRST_LAT  = (STARTUP + 1) * FRAME_CLKS + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic                i2s_sd = 1'b0;
    logic                i2s_bclk;
    logic                i2s_lrclk;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] mic_A_out;
    logic [SAMPLE_W-1:0] mic_B_out;

    int tests = 0;
    int fails = 0;

    // scoreboard and monitor state
    logic [31:0] exp_q[$];
    logic [31:0] exp_pair;
    logic [31:0] last_exp = '0;
    int          n_strobes = 0;
    int          last_strobe_cyc = 0;
    int          cyc = 0;
    bit          hold_reported = 0;
    logic        prev_lr = 0, prev_bclk = 0, prev_en = 0, prev_rst = 1;

    // mic model state
    logic [23:0] word_l = 24'h0, word_r = 24'h0;
    logic [23:0] frm_l = 24'h0, frm_r = 24'h0;
    int          mdl_cnt = 0;
    int          mdl_frame = 0;
    logic        mdl_prev = 0;
    logic        mdl_bclk = 0;
    logic        mdl_bit = 0;
    logic [2:0]  sd_pipe = '0;

    i2s_stereo_rx #(
        .CLK_DIV        (CLK_DIV),
        .SAMPLE_W       (SAMPLE_W),
        .SLOT_BITS      (SLOT_BITS),
        .STARTUP_FRAMES (STARTUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sd       (i2s_sd),
        .sample_valid (sample_valid),
        .mic_A_out    (mic_A_out),
        .mic_B_out    (mic_B_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Mic pair: changes data on BCLK falls, one-bit delay, 24-bit words,
    // a few clk of output delay. Pushes the expected pair at each frame end.
    always @(posedge clk) begin
        #1;
        sd_pipe = {sd_pipe[1:0], mdl_bit};
        i2s_sd  = sd_pipe[2];
        if (rst || !enable) begin
            mdl_cnt   = 0;
            mdl_prev  = 0;
            mdl_frame = 0;
            mdl_bit   = 0;
            frm_l     = word_l;
            frm_r     = word_r;
        end else if (mdl_bclk && !i2s_bclk) begin
            if (i2s_lrclk != mdl_prev) begin
                mdl_cnt = 0;
                if (!i2s_lrclk) begin
                    if (mdl_frame >= STARTUP) exp_q.push_back({frm_l[23:8], frm_r[23:8]});
                    mdl_frame++;
                    frm_l = word_l;
                    frm_r = word_r;
                end
            end else begin
                mdl_cnt++;
            end
            mdl_prev = i2s_lrclk;
            if (mdl_cnt >= 1 && mdl_cnt <= 24)
                mdl_bit = i2s_lrclk ? frm_r[24-mdl_cnt] : frm_l[24-mdl_cnt];
            else
                mdl_bit = 1'b0;
        end
        mdl_bclk = i2s_bclk;
    end

    // Output monitor: strobe data, hold between strobes, LRCLK edge placement
    always @(negedge clk) begin
        if (rst) begin
            last_exp = '0;
        end else if (sample_valid) begin
            n_strobes++;
            last_strobe_cyc = cyc;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: got A=%h B=%h, required no strobe", mic_A_out, mic_B_out);
            end else begin
                exp_pair = exp_q.pop_front();
                last_exp = exp_pair;
                if ({mic_A_out, mic_B_out} !== exp_pair) begin
                    fails++;
                    $display("FAIL strobe_data: got A=%h B=%h, required A=%h B=%h",
                             mic_A_out, mic_B_out, exp_pair[31:16], exp_pair[15:0]);
                end
            end
        end else if ({mic_A_out, mic_B_out} !== last_exp && !hold_reported) begin
            tests++;
            fails++;
            hold_reported = 1;
            $display("FAIL output_hold: got A=%h B=%h, required A=%h B=%h",
                     mic_A_out, mic_B_out, last_exp[31:16], last_exp[15:0]);
        end
        if (!rst && !prev_rst && enable && prev_en && (i2s_lrclk !== prev_lr) &&
            !(prev_bclk === 1'b1 && i2s_bclk === 1'b0)) begin
            tests++;
            fails++;
            $display("FAIL lrclk_edge: got lrclk change with bclk %b->%b, required a bclk fall",
                     prev_bclk, i2s_bclk);
        end
        prev_lr   = i2s_lrclk;
        prev_bclk = i2s_bclk;
        prev_en   = enable;
        prev_rst  = rst;
    end

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int target;
        int k;
        target = n_strobes + n;
        k = 0;
        while (n_strobes < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        ok = (n_strobes >= target);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (i2s_bclk !== 1'b0) begin fails++; $display("FAIL reset_bclk: got %b, required 0", i2s_bclk); end
        tests++; if (i2s_lrclk !== 1'b0) begin fails++; $display("FAIL reset_lrclk: got %b, required 0", i2s_lrclk); end
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", sample_valid); end
        tests++; if (mic_A_out !== 16'h0) begin fails++; $display("FAIL reset_mic_a: got %h, required 0000", mic_A_out); end
        tests++; if (mic_B_out !== 16'h0) begin fails++; $display("FAIL reset_mic_b: got %h, required 0000", mic_B_out); end
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // No strobe during the first STARTUP frames; the first one carries the
    // words that were only presented from frame STARTUP+1 onwards.
    task automatic test_warmup();
        int n;
        word_l = 24'hA5A5A5;
        word_r = 24'h5A5A5A;
        @(negedge clk); #1;
        enable = 1'b1;
        n = 0;
        while (n < FIRST_LAT + 100) begin
            @(negedge clk); #1;
            n++;
            if (n == 2 * FRAME_CLKS + 100) begin
                word_l = 24'h3C3C3C;
                word_r = 24'hC3C3C3;
            end
            if (sample_valid) break;
        end
        tests++;
        if (n != FIRST_LAT) begin fails++; $display("FAIL warmup_latency: got %0d cycles, required %0d", n, FIRST_LAT); end
        tests++;
        if (mic_A_out !== 16'h3C3C || mic_B_out !== 16'hC3C3) begin
            fails++;
            $display("FAIL warmup_first_data: got A=%h B=%h, required A=3c3c B=c3c3", mic_A_out, mic_B_out);
        end
    endtask

    task automatic test_clock_gen();
        int k, hi, lo, per;
        logic p, q;
        k = 0;
        p = i2s_bclk;
        while (k < 100) begin
            @(negedge clk); k++;
            q = p; p = i2s_bclk;
            if (!q && p) break;
        end
        hi = 1;
        while (k < 200) begin @(negedge clk); k++; if (i2s_bclk) hi++; else break; end
        lo = 1;
        while (k < 300) begin @(negedge clk); k++; if (!i2s_bclk) lo++; else break; end
        tests++; if (hi != CLK_DIV) begin fails++; $display("FAIL bclk_high: got %0d, required %0d", hi, CLK_DIV); end
        tests++; if (lo != CLK_DIV) begin fails++; $display("FAIL bclk_low: got %0d, required %0d", lo, CLK_DIV); end
        k = 0;
        p = i2s_lrclk;
        while (k < 2 * FRAME_CLKS) begin
            @(negedge clk); k++;
            q = p; p = i2s_lrclk;
            if (!q && p) break;
        end
        per = 0;
        while (per < 2 * FRAME_CLKS) begin
            @(negedge clk); per++;
            q = p; p = i2s_lrclk;
            if (!q && p) break;
        end
        tests++; if (per != FRAME_CLKS) begin fails++; $display("FAIL lrclk_period: got %0d, required %0d", per, FRAME_CLKS); end
    endtask

    task automatic test_capture();
        bit ok;
        int t0;
        word_l = 24'h123456;
        word_r = 24'hFEDCBA;
        wait_strobes(2, 2 * FRAME_CLKS + 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL capture_timeout: got %0d strobes, required 2 more", n_strobes); end
        tests++; if (mic_A_out !== 16'h1234) begin fails++; $display("FAIL capture_mic_a: got %h, required 1234", mic_A_out); end
        tests++; if ($signed(mic_B_out) != -292) begin fails++; $display("FAIL capture_mic_b: got %0d, required -292", $signed(mic_B_out)); end
        t0 = last_strobe_cyc;
        wait_strobes(1, FRAME_CLKS + 50, ok);
        tests++;
        if (!ok || (last_strobe_cyc - t0) != FRAME_CLKS) begin
            fails++;
            $display("FAIL strobe_period: got %0d, required %0d", last_strobe_cyc - t0, FRAME_CLKS);
        end
    endtask

    task automatic test_sign_extremes();
        bit ok;
        word_l = 24'h800000;
        word_r = 24'h7FFFFF;
        wait_strobes(2, 2 * FRAME_CLKS + 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL sign_timeout: got %0d strobes, required 2 more", n_strobes); end
        tests++; if ($signed(mic_A_out) != -32768) begin fails++; $display("FAIL sign_mic_a: got %0d, required -32768", $signed(mic_A_out)); end
        tests++; if ($signed(mic_B_out) != 32767) begin fails++; $display("FAIL sign_mic_b: got %0d, required 32767", $signed(mic_B_out)); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            word_l = 24'($urandom);
            word_r = 24'($urandom);
            wait_strobes(1, FRAME_CLKS + 50, ok);
            tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout: frame %0d got no strobe, required one", i); end
        end
        wait_strobes(1, FRAME_CLKS + 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_tail: got no strobe, required one"); end
    endtask

    task automatic test_enable_drop();
        int k, n, s0;
        logic [31:0] held;
        held = last_exp;
        k = 0;
        while (k < 2 * FRAME_CLKS) begin
            @(negedge clk); #1; k++;
            if (i2s_lrclk && mdl_cnt == SLOT_BITS + 8 - SLOT_BITS && i2s_bclk) break;
        end
        tests++; if (k >= 2 * FRAME_CLKS) begin fails++; $display("FAIL drop_slot40_timeout: got %0d cycles, required slot 40", k); end
        s0 = n_strobes;
        enable = 1'b0;
        @(negedge clk); #1;
        tests++; if (i2s_bclk !== 1'b0) begin fails++; $display("FAIL drop_bclk: got %b, required 0", i2s_bclk); end
        tests++; if (i2s_lrclk !== 1'b0) begin fails++; $display("FAIL drop_lrclk: got %b, required 0", i2s_lrclk); end
        tests++;
        if ({mic_A_out, mic_B_out} !== held) begin
            fails++;
            $display("FAIL drop_hold: got A=%h B=%h, required A=%h B=%h", mic_A_out, mic_B_out, held[31:16], held[15:0]);
        end
        repeat (2 * FRAME_CLKS) @(negedge clk);
        tests++; if (n_strobes != s0) begin fails++; $display("FAIL drop_no_strobe: got %0d strobes, required 0", n_strobes - s0); end
        word_l = 24'h0F1E2D;
        word_r = 24'hF0E1D2;
        #1 enable = 1'b1;
        n = 0;
        while (n < FIRST_LAT + 100) begin
            @(negedge clk); #1; n++;
            if (sample_valid) break;
        end
        tests++; if (n != FIRST_LAT) begin fails++; $display("FAIL rewarm_latency: got %0d cycles, required %0d", n, FIRST_LAT); end
    endtask

    task automatic test_reset_mid_run();
        int k, n, rise_n;
        k = 0;
        while (k < 2 * FRAME_CLKS) begin
            @(negedge clk); #1; k++;
            if (i2s_lrclk && mdl_cnt == 5 && i2s_bclk) break;
        end
        rst = 1'b1;
        #1;
        tests++; if (i2s_bclk !== 1'b0) begin fails++; $display("FAIL midrst_bclk: got %b, required 0", i2s_bclk); end
        tests++; if (i2s_lrclk !== 1'b0) begin fails++; $display("FAIL midrst_lrclk: got %b, required 0", i2s_lrclk); end
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b, required 0", sample_valid); end
        tests++;
        if (mic_A_out !== 16'h0 || mic_B_out !== 16'h0) begin
            fails++;
            $display("FAIL midrst_outputs: got A=%h B=%h, required 0000 0000", mic_A_out, mic_B_out);
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        rise_n = 0;
        while (n < FIRST_LAT + 100) begin
            @(negedge clk); #1; n++;
            if (i2s_bclk && rise_n == 0) rise_n = n;
            if (sample_valid) break;
        end
        tests++; if (rise_n != CLK_DIV + 1) begin fails++; $display("FAIL midrst_first_rise: got %0d, required %0d", rise_n, CLK_DIV + 1); end
        tests++; if (n != FIRST_LAT) begin fails++; $display("FAIL midrst_latency: got %0d cycles, required %0d", n, FIRST_LAT); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_clock_gen();
        test_capture();
        test_sign_extremes();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_run();
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
